ir_transmitter: RTL and testbench

IR_TRANSMITTER -- requirements
Module: ir_transmitter

---
 rtl/nec_ir_pkg.sv | 30 +++
 rtl/ir_carrier_gen.sv | 32 +++
 rtl/ir_transmitter.sv | 137 +++++++++++++
 tb/tb_ir_transmitter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// Shared NEC IR definitions: FSM state encoding, frame timing in units,
// and a width helper for parameter-sized counters.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_GAP
  } ir_state_t;

  localparam int LEAD_MARK       = 16;
  localparam int LEAD_SPACE_DATA = 8;
  localparam int LEAD_SPACE_REP  = 4;
  localparam int ZERO_SPACE      = 1;
  localparam int ONE_SPACE       = 3;
  localparam int BIT_COUNT       = 32;

  // Bits needed to represent max_val (at least 1).
  function automatic int nec_width(input int max_val);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w++;
    return w;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier counter for the IR LED: restarts while the envelope is idle so
// every mark opens on the high half of the carrier.
module ir_carrier_gen
  import nec_ir_pkg::*;
#(
  parameter int CARRIER_PERIOD = 1316,
  parameter int CARRIER_HIGH   = 658
) (
  input  logic clk,
  input  logic res,
  input  logic i_restart,
  input  logic i_env,
  output logic o_out
);

  localparam int CW = nec_width(CARRIER_PERIOD);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt <= '0;
    end else if (i_restart || r_cnt == CW'(CARRIER_PERIOD - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_out = i_env && (r_cnt < CW'(CARRIER_HIGH));

endmodule

// File: rtl/ir_transmitter.sv
// NEC IR frame transmitter: sends 32-bit data frames or repeat frames as a
// unit-timed mark/space envelope plus its carrier-modulated version.
module ir_transmitter
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYCLES    = 28125,
  parameter int CARRIER_PERIOD = 1316,
  parameter int CARRIER_HIGH   = 658,
  parameter int GAP_UNITS      = 72
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        repeat_req,
  input  logic [31:0] code,
  output logic        busy,
  output logic        done,
  output logic        ir_env,
  output logic        ir_out
);

  localparam int PW   = nec_width(UNIT_CYCLES - 1);
  localparam int MAXU = (GAP_UNITS > LEAD_MARK) ? GAP_UNITS : LEAD_MARK;
  localparam int UW   = nec_width(MAXU);

  ir_state_t     r_state;
  logic [PW-1:0] r_presc;
  logic [UW-1:0] r_units;
  logic [31:0]   r_shift;
  logic [4:0]    r_bit_cnt;
  logic          r_repeat;
  logic          r_busy;
  logic          r_done;
  logic          r_env;

  logic [UW-1:0] w_dur;
  logic          w_unit_end;
  logic          w_state_end;

  always_comb begin
    w_dur = UW'(1);
    case (r_state)
      ST_LEAD_MARK:  w_dur = UW'(LEAD_MARK);
      ST_LEAD_SPACE: w_dur = r_repeat ? UW'(LEAD_SPACE_REP) : UW'(LEAD_SPACE_DATA);
      ST_BIT_SPACE:  w_dur = r_shift[0] ? UW'(ONE_SPACE) : UW'(ZERO_SPACE);
      ST_GAP:        w_dur = UW'(GAP_UNITS);
      default:       w_dur = UW'(1);
    endcase
  end

  assign w_unit_end  = (r_presc == PW'(UNIT_CYCLES - 1));
  assign w_state_end = w_unit_end && (r_units == w_dur - UW'(1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_units   <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_repeat  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_env     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start || repeat_req) begin
          r_state   <= ST_LEAD_MARK;
          r_shift   <= code;
          r_repeat  <= !start;
          r_bit_cnt <= '0;
          r_presc   <= '0;
          r_units   <= '0;
          r_busy    <= 1'b1;
          r_env     <= 1'b1;
        end
      end else begin
        r_presc <= w_unit_end ? '0 : r_presc + PW'(1);
        if (!w_state_end) begin
          if (w_unit_end) r_units <= r_units + UW'(1);
        end else begin
          r_units <= '0;
          case (r_state)
            ST_LEAD_MARK: begin
              r_state <= ST_LEAD_SPACE;
              r_env   <= 1'b0;
            end
            ST_LEAD_SPACE: begin
              r_state <= r_repeat ? ST_STOP_MARK : ST_BIT_MARK;
              r_env   <= 1'b1;
            end
            ST_BIT_MARK: begin
              r_state <= ST_BIT_SPACE;
              r_env   <= 1'b0;
            end
            ST_BIT_SPACE: begin
              // LSB goes first; shift the next bit into position 0.
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_state   <= (r_bit_cnt == 5'(BIT_COUNT - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
              r_env     <= 1'b1;
            end
            ST_STOP_MARK: begin
              r_state <= ST_GAP;
              r_env   <= 1'b0;
            end
            ST_GAP: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign ir_env = r_env;

  // Every mark is entered from a space, so holding the carrier at zero
  // while the envelope is low restarts it at each mark boundary.
  ir_carrier_gen #(
    .CARRIER_PERIOD(CARRIER_PERIOD),
    .CARRIER_HIGH  (CARRIER_HIGH)
  ) u_carrier (
    .clk      (clk),
    .res      (res),
    .i_restart(~r_env),
    .i_env    (r_env),
    .o_out    (ir_out)
  );

endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench: builds each frame's expected waveform from NEC segment
// rules and compares {busy,done,ir_env,ir_out} on every cycle.
module tb_ir_transmitter;

  localparam int UC = 10;
  localparam int GU = 8;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic        repeat_req = 1'b0;
  logic [31:0] code = '0;
  logic        busy, done, ir_env, ir_out;

  int checks = 0;
  int errors = 0;

  bit exp_env [0:2047];
  bit exp_out [0:2047];
  int exp_len;

  int mon_busy, mon_done, mon_env_hi;

  always #5 clk = ~clk;

  ir_transmitter #(
    .UNIT_CYCLES   (UC),
    .CARRIER_PERIOD(4),
    .CARRIER_HIGH  (2),
    .GAP_UNITS     (GU)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .repeat_req(repeat_req),
    .code      (code),
    .busy      (busy),
    .done      (done),
    .ir_env    (ir_env),
    .ir_out    (ir_out)
  );

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // A segment is a level held for a number of units; marks carry 1,1,0,0.
  task automatic add_seg(input bit level, input int units);
    for (int j = 0; j < units * UC; j++) begin
      exp_env[exp_len] = level;
      exp_out[exp_len] = level && ((j % 4) < 2);
      exp_len++;
    end
  endtask

  task automatic build_frame(input bit rep, input logic [31:0] c);
    exp_len = 0;
    add_seg(1'b1, 16);
    add_seg(1'b0, rep ? 4 : 8);
    if (!rep) begin
      for (int b = 0; b < 32; b++) begin
        add_seg(1'b1, 1);
        add_seg(1'b0, c[b] ? 3 : 1);
      end
    end
    add_seg(1'b1, 1);
    add_seg(1'b0, GU);
  endtask

  task automatic check_cycle(input int i);
    logic [3:0] expv;
    logic [3:0] got;
    if (i < exp_len)       expv = {1'b1, 1'b0, exp_env[i], exp_out[i]};
    else if (i == exp_len) expv = 4'b0100;
    else                   expv = 4'b0000;
    got = {busy, done, ir_env, ir_out};
    chk($sformatf("cyc%0d busy,done,env,out", i), int'(got), int'(expv));
    if (busy)   mon_busy++;
    if (done)   mon_done++;
    if (ir_env) mon_env_hi++;
  endtask

  // Runs one request; the bench's own model decides the frame content.
  task automatic run_frame(input string tag, input bit s, input bit r,
                           input logic [31:0] c, input int lit_len,
                           input int lit_env_hi, input int inject_at,
                           input logic [31:0] inject_code, input int abort_at);
    int bad;
    build_frame(!s, c);
    chk({tag, " model length"}, exp_len, lit_len);
    mon_busy = 0; mon_done = 0; mon_env_hi = 0;
    @(negedge clk);
    start = s; repeat_req = r; code = c;
    @(negedge clk);
    start = 1'b0; repeat_req = 1'b0;
    for (int i = 0; i <= exp_len + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_at) begin
        res = 1'b1;
        #1;
        chk({tag, " outputs in reset"}, int'({busy, done, ir_env, ir_out}), 0);
        @(posedge clk);
        #1 res = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (busy || done || ir_env || ir_out) bad++;
        end
        chk({tag, " quiet after abort"}, bad, 0);
        return;
      end
      check_cycle(i);
      if (i == 0) code = ~c;
      if (i == inject_at) begin
        start = 1'b1; code = inject_code;
      end
      if (i == inject_at + 1) start = 1'b0;
    end
    chk({tag, " busy cycles"}, mon_busy, lit_len);
    chk({tag, " done pulses"}, mon_done, 1);
    chk({tag, " env high cycles"}, mon_env_hi, lit_env_hi);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2;
    chk("reset outputs", int'({busy, done, ir_env, ir_out}), 0);
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle outputs", int'({busy, done, ir_env, ir_out}), 0);

    // 16 ones: 24+32+64+1+8 = 129 units
    run_frame("data_00FF00FF", 1'b1, 1'b0, 32'h00FF00FF, 1290, 490, -10, 32'h0, -1);
    build_frame(1'b0, 32'h00FF00FF);
    chk("model lead mark end", int'(exp_env[159]), 1);
    chk("model lead space start", int'(exp_env[160]), 0);
    chk("model lead space end", int'(exp_env[239]), 0);
    chk("model first bit mark", int'(exp_env[240]), 1);

    run_frame("repeat", 1'b0, 1'b1, 32'h0, 290, 170, -10, 32'h0, -1);
    build_frame(1'b1, 32'h0);
    chk("model rep space end", int'(exp_env[199]), 0);
    chk("model rep stop mark", int'(exp_env[200]), 1);
    chk("model rep gap start", int'(exp_env[210]), 0);

    // bit0=1 then 31 zeros: 24+32+(3+31)+1+8 = 99 units
    run_frame("data_00000001", 1'b1, 1'b0, 32'h00000001, 990, 490, -10, 32'h0, -1);
    build_frame(1'b0, 32'h00000001);
    chk("model bit0 space", int'(exp_env[279]), 0);
    chk("model bit1 mark", int'(exp_env[280]), 1);
    chk("model bit1 space len", int'(exp_env[291]), 0);
    chk("model bit2 mark", int'(exp_env[300]), 1);

    // start+repeat_req together: data frame; a start at busy cycle 50 is dropped
    run_frame("both_A5A53C3C", 1'b1, 1'b1, 32'hA5A53C3C, 1290, 490, 50, 32'hFFFFFFFF, -1);

    run_frame("abort", 1'b1, 1'b0, 32'h0000FFFF, 1290, 490, -10, 32'h0, 500);

    // 13 ones: 24+32+58+1+8 = 123 units
    run_frame("data_12345678", 1'b1, 1'b0, 32'h12345678, 1230, 490, -10, 32'h0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
